// File: rtl/auth_resp_serializer.sv
// auth_resp_serializer: streams the challenge response, or a 4-byte ERROR header,
// MSB byte first over a valid/ready byte interface.
module auth_resp_serializer #(
  parameter int         MSG_LEN          = 256,
  parameter int         HDR_LEN          = 32,
  parameter logic [7:0] PROTOCOL_VERSION = 8'h01,
  parameter logic [7:0] ERROR_CMD        = 8'h7F,
  parameter logic [7:0] ERR_INVALID_REQ  = 8'h01
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [HDR_LEN-1:0]         header,
  input  logic [MSG_LEN-HDR_LEN-1:0] payload,
  input  logic                       Ack_in,
  input  logic                       Error_in,
  input  logic                       tx_ready,
  input  logic                       clear_overrun,
  output logic [7:0]                 tx_byte,
  output logic                       tx_valid,
  output logic                       tx_last,
  output logic                       busy,
  output logic                       overrun
);
  typedef enum logic {IDLE, SEND} state_e;
  state_e             state_q, state_d;
  logic [MSG_LEN-1:0] sr_q, sr_d;
  logic [5:0]         cnt_q, cnt_d, len_q, len_d;
  logic               ack_prev_q, err_prev_q, overrun_q, overrun_d;
  logic               ack_rise, err_rise;
  assign ack_rise = Ack_in & ~ack_prev_q;
  assign err_rise = Error_in & ~err_prev_q;
  assign overrun  = overrun_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      ack_prev_q <= 1'b0;
      err_prev_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      ack_prev_q <= Ack_in;
      err_prev_q <= Error_in;
      overrun_q  <= overrun_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    busy      = state_q == SEND;
    tx_valid  = busy;
    tx_byte   = busy ? sr_q[MSG_LEN-1 -: 8] : 8'h00;
    tx_last   = busy && (cnt_q == len_q - 6'd1);
    // a rise while busy is dropped but flagged; set beats a simultaneous clear
    overrun_d = (busy & (ack_rise | err_rise)) | (overrun_q & ~clear_overrun);
    if (!busy && ack_rise) begin
      state_d = SEND;
      sr_d    = {header, payload};
      len_d   = 6'(MSG_LEN / 8);
      cnt_d   = '0;
    end else if (!busy && err_rise) begin
      state_d = SEND;
      sr_d    = {PROTOCOL_VERSION, ERROR_CMD, ERR_INVALID_REQ, 8'h00, {(MSG_LEN-32){1'b0}}};
      len_d   = 6'd4;
      cnt_d   = '0;
    end else if (tx_valid && tx_ready) begin
      sr_d    = sr_q << 8;
      cnt_d   = cnt_q + 6'd1;
      state_d = tx_last ? IDLE : SEND;
    end
  end
endmodule

// File: tb/tb_auth_resp_serializer.sv
// tb_auth_resp_serializer: directed vectors for the response/ERROR byte serializer.
module tb_auth_resp_serializer;
  logic         clk = 0, reset_n = 0;
  logic [31:0]  header = 32'h01030F01;
  logic [223:0] payload = '0;
  logic         Ack_in = 0, Error_in = 0, tx_ready = 1, clear_overrun = 0;
  logic [7:0]   tx_byte;
  logic         tx_valid, tx_last, busy, overrun;
  int           checks = 0, failures = 0, vcnt;

  auth_resp_serializer dut (
    .clk(clk), .reset_n(reset_n), .header(header), .payload(payload),
    .Ack_in(Ack_in), .Error_in(Error_in), .tx_ready(tx_ready),
    .clear_overrun(clear_overrun), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_last(tx_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // payload byte j is j+1, so message byte k >= 4 is k-3
  function automatic logic [7:0] exp_byte(input int k, input bit err);
    if (err) return k == 1 ? 8'h7F : k == 3 ? 8'h00 : 8'h01;
    if (k < 4) return k == 1 ? 8'h03 : k == 2 ? 8'h0F : 8'h01;
    return 8'(k - 3);
  endfunction

  task automatic recv(input int n, input bit err, input bit stall, input int ovr_at, input bit hold);
    int got = 0, cyc = 0, st = 0;
    bit od = 0;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (got == ovr_at && !od) begin
        Ack_in = 1;
        od = 1;
      end else if (!hold) begin
        Ack_in = 0;
        Error_in = 0;
      end
      tx_ready = !(stall && got == 1 && st < 2);
      check("valid", 32'(tx_valid), 1);
      check("busy", 32'(busy), 1);
      if (!tx_ready) begin
        st++;
        check("stall_byte", 32'(tx_byte), 32'(exp_byte(1, err)));
      end else begin
        check($sformatf("byte%0d", got), 32'(tx_byte), 32'(exp_byte(got, err)));
        check($sformatf("last%0d", got), 32'(tx_last), 32'(got == n - 1));
        got++;
      end
    end
    check("count", 32'(got), 32'(n));
    @(negedge clk);
    tx_ready = 1;
    if (!hold) begin
      Ack_in = 0;
      Error_in = 0;
    end
    check("done_valid", 32'(tx_valid), 0);
    check("done_busy", 32'(busy), 0);
  endtask

  task automatic idle_cycles(input int n);
    vcnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx_valid) vcnt++;
    end
  endtask

  initial begin
    for (int j = 0; j < 28; j++) payload[223-8*j -: 8] = 8'(j + 1);
    repeat (2) @(negedge clk);
    check("rst_out", {20'h0, tx_byte, tx_valid, tx_last, busy, overrun}, 0);
    reset_n = 1;
    idle_cycles(3);
    check("rst_idle", 32'(vcnt), 0);

    @(negedge clk); Ack_in = 1;
    recv(32, 0, 0, -1, 0);

    @(negedge clk); Error_in = 1;
    recv(4, 1, 0, -1, 0);

    @(negedge clk); Ack_in = 1;
    recv(32, 0, 1, -1, 0);
    check("ovr_clean", 32'(overrun), 0);

    @(negedge clk); Ack_in = 1;
    recv(32, 0, 0, 9, 0);
    check("ovr_set", 32'(overrun), 1);
    idle_cycles(5);
    check("no_second", 32'(vcnt), 0);
    check("ovr_sticky", 32'(overrun), 1);
    clear_overrun = 1;
    @(negedge clk); clear_overrun = 0;
    check("ovr_clr", 32'(overrun), 0);

    @(negedge clk); Ack_in = 1; Error_in = 1;
    recv(32, 0, 0, -1, 1);
    idle_cycles(67);
    check("held_once", 32'(vcnt), 0);
    check("held_ovr", 32'(overrun), 0);
    Ack_in = 0; Error_in = 0;
    idle_cycles(2);

    @(negedge clk); Ack_in = 1;
    @(negedge clk); Ack_in = 0;
    repeat (2) @(negedge clk);
    check("mid_valid", 32'(tx_valid), 1);
    reset_n = 0;
    #1;
    check("mid_rst", {20'h0, tx_byte, tx_valid, tx_last, busy, overrun}, 0);
    @(negedge clk); reset_n = 1;
    idle_cycles(5);
    check("post_rst", 32'(vcnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
